// File: rtl/jtpopeye_pkg.sv
// Shared definitions for the Popeye sprite DMA: state encoding, object
// buffer base and default transfer length.
package jtpopeye_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    REL  = 2'd3
  } dma_state_t;

  localparam logic [9:0] OBJ_BASE = 10'h000;
  localparam int         DMA_LEN  = 1024;

endpackage

// File: rtl/jtpopeye_dma_pipe.sv
// Two-stage address/valid delay line matching the registered main RAM read.
// Stage B is the object-buffer write strobe, so its valid is a one-clk pulse.
module jtpopeye_dma_pipe #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [AW-1:0] in_addr,
  output logic          a_valid,
  output logic          b_valid,
  output logic [AW-1:0] b_addr
);

  logic [AW-1:0] a_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid <= 1'b0;
      a_addr  <= '0;
      b_valid <= 1'b0;
      b_addr  <= '0;
    end else begin
      b_valid <= 1'b0;
      if (cen) begin
        if (flush) begin
          a_valid <= 1'b0;
        end else begin
          a_valid <= in_valid;
          a_addr  <= in_addr;
          b_valid <= a_valid;
          // b_addr holds the last written address between strobes
          if (a_valid) b_addr <= a_addr;
        end
      end
    end
  end

endmodule

// File: rtl/jtpopeye_dma.sv
// Sprite DMA master: on VB rising edge grabs the Z80 bus and copies the
// object area of main RAM into the object line buffer, one byte per cen.
//
// state | meaning
// IDLE  | waiting for VB rising edge, bus released
// REQ   | busrq_n low, waiting for busak_n
// XFER  | reading RAM / writing object buffer
// REL   | busrq_n high, waiting for busak_n to return high
module jtpopeye_dma
  import jtpopeye_pkg::*;
#(
  parameter int LEN = DMA_LEN,
  parameter int AW  = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          VB,
  input  logic          busak_n,
  input  logic [7:0]    DD_DMA,
  output logic          busrq_n,
  output logic          dma_cs,
  output logic [AW-1:0] AD_DMA,
  output logic          obj_we,
  output logic [AW-1:0] obj_addr,
  output logic [7:0]    obj_data,
  output logic          busy,
  output logic          done
);

  localparam logic [AW:0]   LEN_W   = (AW+1)'(LEN);
  localparam logic [AW-1:0] LAST    = AW'(LEN-1);
  localparam logic [AW-1:0] OBJ_OFS = AW'(OBJ_BASE);

  dma_state_t    state, state_nx;
  logic          VBl;
  logic [AW:0]   rd_cnt, rd_nx;
  logic [AW-1:0] wr_cnt, wr_nx;
  logic [AW-1:0] ad_nx;
  logic          busrq_nx, dma_cs_nx, busy_nx, done_nx;
  logic          issue, flush;
  logic          a_valid, b_valid;
  logic [AW-1:0] b_addr;

  jtpopeye_dma_pipe #(.AW(AW)) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .cen      (cen),
    .flush    (flush),
    .in_valid (issue),
    .in_addr  (AD_DMA),
    .a_valid  (a_valid),
    .b_valid  (b_valid),
    .b_addr   (b_addr)
  );

  assign obj_we   = b_valid;
  assign obj_addr = b_addr + OBJ_OFS;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      VBl      <= 1'b0;
      busrq_n  <= 1'b1;
      dma_cs   <= 1'b0;
      AD_DMA   <= '0;
      rd_cnt   <= '0;
      wr_cnt   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      obj_data <= 8'd0;
    end else begin
      done <= 1'b0;
      if (cen) begin
        state   <= state_nx;
        VBl     <= VB;
        busrq_n <= busrq_nx;
        dma_cs  <= dma_cs_nx;
        AD_DMA  <= ad_nx;
        rd_cnt  <= rd_nx;
        wr_cnt  <= wr_nx;
        busy    <= busy_nx;
        done    <= done_nx;
        if (a_valid && !flush) obj_data <= DD_DMA;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    busrq_nx  = busrq_n;
    dma_cs_nx = dma_cs;
    busy_nx   = busy;
    done_nx   = 1'b0;
    ad_nx     = AD_DMA;
    rd_nx     = rd_cnt;
    wr_nx     = wr_cnt;
    issue     = 1'b0;
    flush     = 1'b0;
    case (state)
      IDLE: begin
        if (VB && !VBl) begin
          state_nx = REQ;
          busrq_nx = 1'b0;
          busy_nx  = 1'b1;
        end
      end
      REQ: begin
        busrq_nx = 1'b0;
        if (!busak_n) begin
          state_nx  = XFER;
          dma_cs_nx = 1'b1;
          ad_nx     = '0;
          rd_nx     = '0;
          wr_nx     = '0;
        end
      end
      XFER: begin
        if (busak_n) begin
          // bus lost: drop everything in flight, no done
          flush     = 1'b1;
          state_nx  = IDLE;
          dma_cs_nx = 1'b0;
          busrq_nx  = 1'b1;
          busy_nx   = 1'b0;
        end else begin
          if (rd_cnt < LEN_W) begin
            issue = 1'b1;
            rd_nx = rd_cnt + 1'b1;
            if (AD_DMA != LAST) ad_nx = AD_DMA + 1'b1;
          end
          if (a_valid) begin
            wr_nx = wr_cnt + 1'b1;
            if (wr_cnt == LAST) begin
              state_nx  = REL;
              dma_cs_nx = 1'b0;
              busrq_nx  = 1'b1;
            end
          end
        end
      end
      REL: begin
        dma_cs_nx = 1'b0;
        busrq_nx  = 1'b1;
        if (busak_n) begin
          done_nx  = 1'b1;
          busy_nx  = 1'b0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_jtpopeye_dma.sv
// Bench for jtpopeye_dma: Z80/RAM models, write scoreboard, scenario table.
module tb_jtpopeye_dma;
  localparam int LEN = 1024;
  localparam int AW  = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cen = 1'b0;
  logic          VB  = 1'b0;
  logic          busak_n = 1'b1;
  logic [7:0]    DD_DMA = 8'd0;
  logic          busrq_n, dma_cs, obj_we, busy, done;
  logic [AW-1:0] AD_DMA, obj_addr;
  logic [7:0]    obj_data;

  jtpopeye_dma #(.LEN(LEN), .AW(AW)) dut (
    .clk(clk), .rst(rst), .cen(cen), .VB(VB), .busak_n(busak_n),
    .DD_DMA(DD_DMA), .busrq_n(busrq_n), .dma_cs(dma_cs), .AD_DMA(AD_DMA),
    .obj_we(obj_we), .obj_addr(obj_addr), .obj_data(obj_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cdiv = 0;
  always @(negedge clk) begin
    cdiv = (cdiv + 1) % 4;
    cen  = (cdiv == 0);
  end

  // RAM registers read data one cen after the address
  always @(posedge clk) if (cen) DD_DMA <= AD_DMA[7:0] ^ 8'h5A;

  int ack_delay = 0;
  bit pre_ack   = 1'b0;
  bit lose      = 1'b0;
  int ack_cnt   = 0;
  always @(posedge clk) if (cen) begin
    if (lose) busak_n <= 1'b1;
    else if (!busrq_n) begin
      if (ack_cnt >= ack_delay) busak_n <= 1'b0;
      else ack_cnt <= ack_cnt + 1;
    end else begin
      ack_cnt <= 0;
      busak_n <= !pre_ack;
    end
  end

  typedef struct { logic [AW-1:0] addr; logic [7:0] data; } wr_t;
  wr_t exp_q[$];

  int total = 0;
  int bad   = 0;
  int wr_seen = 0;
  int done_seen = 0;
  logic prev_we = 1'b0;

  always @(negedge clk) begin
    if (obj_we) begin
      wr_t e;
      wr_seen++;
      total++;
      if (prev_we) begin
        bad++;
        $display("FAIL we_width obj_we high two clks at addr=%0d", obj_addr);
      end
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL wr_extra got addr=%0d data=%0h, none expected", obj_addr, obj_data);
      end else begin
        e = exp_q.pop_front();
        if (obj_addr !== e.addr || obj_data !== e.data) begin
          bad++;
          $display("FAIL wr_data got addr=%0d data=%0h exp addr=%0d data=%0h",
                   obj_addr, obj_data, e.addr, e.data);
        end
      end
    end
    if (done) done_seen++;
    prev_we = obj_we;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic step_cen(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (!cen);
    end
    #1;
  endtask

  task automatic push_frame();
    for (int i = 0; i < LEN; i++) begin
      wr_t e;
      e.addr = AW'(i);
      e.data = 8'(i) ^ 8'h5A;
      exp_q.push_back(e);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_busrq_n"}, busrq_n, 1);
    check({tag, "_dma_cs"},  dma_cs, 0);
    check({tag, "_AD_DMA"},  AD_DMA, 0);
    check({tag, "_obj_we"},  obj_we, 0);
    check({tag, "_obj_addr"}, obj_addr, 0);
    check({tag, "_obj_data"}, obj_data, 0);
    check({tag, "_busy"},    busy, 0);
    check({tag, "_done"},    done, 0);
  endtask

  typedef struct {
    int ack_delay; int lose_at; int rst_at; bit retrig;
    int min_wr; int max_wr; int exp_done;
  } scen_t;

  initial begin
    scen_t sc[6];
    int n;
    bit fin;

    sc[0] = '{2, -1,  -1, 1'b0, LEN, LEN, 1};   // full transfer
    sc[1] = '{0, -1,  -1, 1'b1, LEN, LEN, 1};   // VB retrigger during XFER
    sc[2] = '{2, 300, -1, 1'b0, 301, 302, 0};   // bus lost after write 300
    sc[3] = '{1, -1,  -1, 1'b0, LEN, LEN, 1};   // restart from address 0
    sc[4] = '{2, -1, 512, 1'b0, 513, 513, 0};   // reset at write 512
    sc[5] = '{5, -1,  -1, 1'b0, LEN, LEN, 1};   // recovery after reset

    repeat (5) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    step_cen(1);
    check_reset_outs("rst");

    step_cen(100);
    check("idle_busrq_n", busrq_n, 1);
    check("idle_dma_cs", dma_cs, 0);
    check("idle_wr", wr_seen, 0);

    // grant already present when busrq_n falls
    pre_ack = 1'b1; ack_delay = 0;
    step_cen(3);
    wr_seen = 0; done_seen = 0;
    push_frame();
    VB = 1'b1;
    step_cen(1);
    check("gl_start_busrq_n", busrq_n, 0);
    check("gl_start_busy", busy, 1);
    step_cen(1);
    check("gl_xfer_dma_cs", dma_cs, 1);
    check("gl_xfer_AD_DMA", AD_DMA, 0);
    step_cen(1);
    check("gl_k1_obj_we", obj_we, 0);
    check("gl_k1_AD_DMA", AD_DMA, 1);
    step_cen(1);
    check("gl_k2_obj_we", obj_we, 1);
    check("gl_k2_obj_addr", obj_addr, 0);
    check("gl_k2_obj_data", obj_data, 8'h5A);
    pre_ack = 1'b0;
    n = 0;
    while (busy && n < 3000) begin step_cen(1); n++; end
    total++;
    if (busy) begin bad++; $display("FAIL gl_timeout busy still high after %0d cens", n); end
    VB = 1'b0;
    step_cen(4);
    check("gl_writes", wr_seen, LEN);
    check("gl_done", done_seen, 1);
    exp_q.delete();

    for (int s = 0; s < 6; s++) begin
      wr_seen = 0; done_seen = 0;
      exp_q.delete();
      push_frame();
      ack_delay = sc[s].ack_delay;
      VB = 1'b1;
      step_cen(1);
      check($sformatf("s%0d_start_busrq_n", s), busrq_n, 0);
      n = 0; fin = 1'b0;
      while (!fin && n < 3000) begin
        step_cen(1);
        n++;
        if (obj_we) begin
          if (sc[s].retrig) begin
            case (int'(obj_addr))
              100: VB = 1'b0;
              200: VB = 1'b1;
              300: VB = 1'b0;
              400: VB = 1'b1;
              default: ;
            endcase
          end
          if (int'(obj_addr) == sc[s].lose_at) lose = 1'b1;
          if (int'(obj_addr) == LEN-1) begin
            check($sformatf("s%0d_last_dma_cs", s), dma_cs, 0);
            check($sformatf("s%0d_last_busrq_n", s), busrq_n, 1);
          end
          if (int'(obj_addr) == sc[s].rst_at) begin
            @(negedge clk);
            rst = 1'b1; VB = 1'b0;
            @(posedge clk); #1;
            check_reset_outs($sformatf("s%0d_midrst", s));
            @(negedge clk) rst = 1'b0;
            fin = 1'b1;
          end
        end
        if (!busy) fin = 1'b1;
      end
      total++;
      if (!fin) begin bad++; $display("FAIL s%0d_timeout busy still high after %0d cens", s, n); end
      VB = 1'b0;
      lose = 1'b0;
      step_cen(4);
      check($sformatf("s%0d_end_busy", s), busy, 0);
      check($sformatf("s%0d_end_busrq_n", s), busrq_n, 1);
      check($sformatf("s%0d_end_dma_cs", s), dma_cs, 0);
      total++;
      if (wr_seen < sc[s].min_wr || wr_seen > sc[s].max_wr) begin
        bad++;
        $display("FAIL s%0d_writes got=%0d exp=%0d..%0d", s, wr_seen, sc[s].min_wr, sc[s].max_wr);
      end
      check($sformatf("s%0d_done", s), done_seen, sc[s].exp_done);
      exp_q.delete();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
